// File: rtl/lut_prog_pkg.sv
// Shared types and sizing for the programmable 6-input LUT writer.
package lut_prog_pkg;

  localparam int LUT_ADDR_W = 6;
  localparam int LUT_DEPTH  = 64;
  localparam int CFG_BYTES  = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } lut_state_t;

  // A frame is well formed only when cfg_last marks exactly the final byte.
  function automatic logic framing_ok(input logic [CNT_W-1:0] cnt, input logic last);
    return last == (cnt == CNT_W'(CFG_BYTES - 1));
  endfunction

endpackage

// File: rtl/lut_prog_table.sv
// Active truth table, registered lookup and optional byte readback (LUT_PROG_READBACK_EN).
module lut_prog_table
  import lut_prog_pkg::*;
#(
  parameter logic [LUT_DEPTH-1:0] RESET_TABLE = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [LUT_DEPTH-1:0]  i_wdata,
  input  logic                  i_lk_valid,
  input  logic [LUT_ADDR_W-1:0] i_lk_addr,
  output logic                  o_valid,
  output logic                  o_bit
`ifdef LUT_PROG_READBACK_EN
  ,
  input  logic [CNT_W-1:0]      i_rb_addr,
  output logic [7:0]            o_rb_data
`endif
);

  logic [LUT_DEPTH-1:0] r_active;
  logic                 r_out_valid;
  logic                 r_out_bit;

  // Lookup reads r_active before the commit write lands, so a request on the
  // swap edge sees the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= RESET_TABLE;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
    end else begin
      r_out_valid <= i_lk_valid;
      if (i_lk_valid) begin
        r_out_bit <= r_active[i_lk_addr];
      end
      if (i_we) begin
        r_active <= i_wdata;
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_bit   = r_out_bit;

`ifdef LUT_PROG_READBACK_EN
  logic [7:0] r_rb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb_data <= 8'h00;
    end else begin
      r_rb_data <= r_active[{i_rb_addr, 3'b000} +: 8];
    end
  end

  assign o_rb_data = r_rb_data;
`endif

endmodule

// File: rtl/lut_prog_writer.sv
// Byte-serial loader for a 64-entry LUT with shadow table and atomic commit.
// Optional readback ports are enabled with LUT_PROG_READBACK_EN.
module lut_prog_writer
  import lut_prog_pkg::*;
#(
  parameter logic [63:0] RESET_TABLE = 64'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       cfg_last,
  input  logic       in_valid,
  input  logic [5:0] in_addr,
  output logic       out_valid,
  output logic       out_bit,
  output logic       cfg_err,
  output logic       tbl_commit
`ifdef LUT_PROG_READBACK_EN
  ,
  input  logic [2:0] rb_addr,
  output logic [7:0] rb_data
`endif
);

  lut_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [LUT_DEPTH-1:0] r_shadow;
  logic                 r_cfg_ready;
  logic                 r_cfg_err;
  logic                 r_tbl_commit;
  logic                 w_accept;
  logic                 w_commit;

  assign w_accept = cfg_valid & r_cfg_ready;
  assign w_commit = (r_state == ST_COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
      r_tbl_commit <= 1'b0;
    end else begin
      r_tbl_commit <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (!w_accept) begin
            if (r_state == ST_IDLE) begin
              r_cnt <= '0;
            end
          end else if (!framing_ok(r_cnt, cfg_last)) begin
            r_cfg_err <= 1'b1;
            r_shadow  <= '0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_shadow[{r_cnt, 3'b000} +: 8] <= cfg_data;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CFG_BYTES - 1)) begin
              r_state      <= ST_COMMIT;
              r_cfg_ready  <= 1'b0;
              r_tbl_commit <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_COMMIT: begin
          // The table module copies r_shadow on this same edge.
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_shadow    <= '0;
          r_cnt       <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign tbl_commit = r_tbl_commit;

  lut_prog_table #(
    .RESET_TABLE(RESET_TABLE)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_commit),
    .i_wdata   (r_shadow),
    .i_lk_valid(in_valid),
    .i_lk_addr (in_addr),
    .o_valid   (out_valid),
    .o_bit     (out_bit)
`ifdef LUT_PROG_READBACK_EN
    ,
    .i_rb_addr (rb_addr),
    .o_rb_data (rb_data)
`endif
  );

endmodule

// File: tb/tb_lut_prog_writer.sv
// Scoreboard bench for lut_prog_writer: lookups queue expected bits, a monitor checks outputs.
module tb_lut_prog_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       in_valid;
  logic [5:0] in_addr;
  logic       out_valid;
  logic       out_bit;
  logic       cfg_err;
  logic       tbl_commit;
`ifdef LUT_PROG_READBACK_EN
  logic [2:0] rb_addr = 3'd0;
  logic [7:0] rb_data;
`endif

  lut_prog_writer #(.RESET_TABLE(64'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .cfg_err   (cfg_err),
    .tbl_commit(tbl_commit)
`ifdef LUT_PROG_READBACK_EN
    ,
    .rb_addr   (rb_addr),
    .rb_data   (rb_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic       bit_v;
  } lk_t;

  localparam logic [63:0] TBL_A = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TBL_B = 64'h8056_3412_F00F_3CA5;
  localparam logic [63:0] TBL_C = 64'h0123_4567_89AB_CDEF;

  int          checks = 0;
  int          errors = 0;
  int          n_commit = 0;
  int          n_ready_low = 0;
  lk_t         exp_q[$];
  logic [63:0] m_active;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented lookup result.
  always @(negedge clk) begin
    if (!rst) begin
      if (tbl_commit) n_commit++;
      if (!cfg_ready) n_ready_low++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("lookup_unexpected", 64'(out_valid), 64'd0);
        end else begin
          lk_t e;
          e = exp_q.pop_front();
          $display("LOOKUP addr=%02h bit=%b exp=%b", e.addr, out_bit, e.bit_v);
          check("lookup_bit", 64'(out_bit), 64'(e.bit_v));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [5:0] addr);
    lk_t e;
    in_valid = 1'b1;
    in_addr  = addr;
    e.addr   = addr;
    e.bit_v  = m_active[addr];
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    repeat (gap) tick();
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    while (!ok && n < 20) begin
      ok = cfg_ready;
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (!ok) check("cfg_accept_timeout", 64'd0, 64'd1);
    $display("CFG byte=%02h last=%b gap=%0d", d, last, gap);
  endtask

  // Full 8-byte load; optionally issues a lookup during the COMMIT cycle.
  task automatic load(input logic [63:0] tbl, input bit gaps, input bit probe, input logic [5:0] paddr);
    int  c0;
    lk_t e;
    c0 = n_commit;
    for (int k = 0; k < 8; k++) begin
      send_byte(tbl[8*k +: 8], (k == 7), gaps ? int'($urandom_range(0, 3)) : 0);
    end
    check("commit_pulse_hi", 64'(tbl_commit), 64'd1);
    check("ready_low_commit", 64'(cfg_ready), 64'd0);
    if (probe) begin
      in_valid = 1'b1;
      in_addr  = paddr;
      e.addr   = paddr;
      e.bit_v  = m_active[paddr];
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    m_active = tbl;
    check("commit_pulse_lo", 64'(tbl_commit), 64'd0);
    check("ready_back_hi", 64'(cfg_ready), 64'd1);
    check("commit_count", 64'(n_commit - c0), 64'd1);
  endtask

  initial begin
    int c0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_addr   = 6'h00;
    m_active  = 64'h0;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bit", 64'(out_bit), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_tbl_commit", 64'(tbl_commit), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0;
    tick();

    lookup(6'h2A);
    tick();

    load(TBL_A, 1'b0, 1'b0, 6'h00);
    lookup(6'h3F);
    lookup(6'h00);

    // Early cfg_last on byte 3.
    c0 = n_commit;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    lookup(6'h00);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    check("err_early_last", 64'(cfg_err), 64'd1);
    check("err_ready", 64'(cfg_ready), 64'd1);
    tick();
    check("err_no_commit", 64'(n_commit - c0), 64'd0);
    lookup(6'h3F);
    lookup(6'h00);

    // Lookup on the commit edge returns the old bit, next one the new bit.
    load(TBL_B, 1'b0, 1'b1, 6'h3F);
    lookup(6'h3F);
    lookup(6'h00);
    lookup(6'h01);
    check("err_sticky", 64'(cfg_err), 64'd1);

    load(TBL_C, 1'b1, 1'b0, 6'h00);
    lookup(6'h00);
    lookup(6'h04);
    lookup(6'h3F);
    lookup(6'h38);
    lookup(6'h1D);

    // Reset mid-load abandons the partial table.
    for (int k = 0; k < 5; k++) send_byte(8'hA0 + 8'(k), 1'b0, 0);
    #2 rst = 1'b1;
    #2;
    m_active = 64'h0;
    check("midrst_cfg_err", 64'(cfg_err), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    check("midrst_ready", 64'(cfg_ready), 64'd1);
    tick();
    lookup(6'h00);
    lookup(6'h38);
    load(TBL_A, 1'b0, 1'b0, 6'h00);
    lookup(6'h00);
    lookup(6'h3F);

    // Missing cfg_last on byte 7.
    c0 = n_commit;
    for (int k = 0; k < 8; k++) send_byte(8'h00, 1'b0, 0);
    check("err_missing_last", 64'(cfg_err), 64'd1);
    tick();
    check("err7_no_commit", 64'(n_commit - c0), 64'd0);
    lookup(6'h00);
    lookup(6'h3F);

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("ready_low_cycles", 64'(n_ready_low), 64'(n_commit));
    check("total_commits", 64'(n_commit), 64'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
